// File: rtl/dist_pkg.sv
// Shared types and constants for the multimode distortion stage: shaping
// modes, the per-sample configuration snapshot and its reset values.
package dist_pkg;

    localparam int DIST_WIDTH     = 16;
    localparam int DIST_GAIN_W    = 8;
    localparam int DIST_GAIN_FRAC = 4;
    localparam int DIST_MIX_W     = 8;

    // Mix value 255 is promoted to this so a full-wet setting passes the
    // wet path unattenuated.
    localparam logic [8:0] MIX_FULL = 9'd256;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        HARD   = 2'd1,
        SOFT   = 2'd2,
        ASYM   = 2'd3
    } dist_mode_e;

    typedef struct packed {
        dist_mode_e                     mode;
        logic [DIST_GAIN_W-1:0]         gain;
        logic signed [DIST_WIDTH-1:0]   threshold;
        logic [DIST_MIX_W-1:0]          mix;
    } dist_cfg_t;

    // Unity gain, no clipping, fully wet.
    localparam dist_cfg_t CFG_RESET = '{
        mode:      BYPASS,
        gain:      {{(DIST_GAIN_W-DIST_GAIN_FRAC-1){1'b0}}, 1'b1, {DIST_GAIN_FRAC{1'b0}}},
        threshold: {1'b0, {(DIST_WIDTH-1){1'b1}}},
        mix:       {DIST_MIX_W{1'b1}}
    };

endpackage

// File: rtl/dist_shaper.sv
// Combinational waveshaper: bypass, symmetric hard clip, odd-symmetric soft
// clip from a 17-point interpolated curve, and asymmetric clip whose
// negative rail sits at half the threshold. The parent registers the result.
module dist_shaper
    import dist_pkg::*;
#(
    parameter int WIDTH = DIST_WIDTH
) (
    input  dist_mode_e               mode,
    input  logic signed [WIDTH-1:0]  threshold,
    input  logic signed [WIDTH-1:0]  x,
    output logic signed [WIDTH-1:0]  y
);

    // Bits of magnitude below the 4-bit curve segment index.
    localparam int FW = WIDTH - 5;
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // Curve breakpoint idx/16 of full scale: y = a*(2 - a), i.e. slope 2
    // at the origin flattening to slope 0 at full scale; clamped to POS_MAX.
    function automatic logic [WIDTH-1:0] knee(input logic [4:0] idx);
        logic [9:0]   p;
        logic [WIDTH:0] v;
        p = {5'd0, idx} * (10'd32 - {5'd0, idx});
        v = {{(WIDTH-9){1'b0}}, p} << (WIDTH-9);
        if (v > {1'b0, POS_MAX}) begin
            knee = POS_MAX;
        end else begin
            knee = WIDTH'(v);
        end
    endfunction

    logic signed [WIDTH-1:0] lo_hard_s;
    logic signed [WIDTH-1:0] lo_asym_s;
    logic                    neg_s;
    logic [WIDTH-1:0]        mag_full_s;
    logic [WIDTH-1:0]        mag_s;
    logic [3:0]              idx_s;
    logic [FW-1:0]           frac_s;
    logic [WIDTH-1:0]        knee_lo_s;
    logic [WIDTH-1:0]        knee_hi_s;
    logic [2*WIDTH-6:0]      interp_s;
    logic [WIDTH-1:0]        soft_mag_s;
    logic signed [WIDTH-1:0] soft_s;

    // Clip rails and the interpolated soft-curve value for the current sample.
    always_comb begin
        lo_hard_s  = -threshold;
        lo_asym_s  = -(threshold >>> 1);
        neg_s      = x[WIDTH-1];
        mag_full_s = neg_s ? -x : x;
        // Most-negative input has no positive twin; fold it onto full scale.
        if (mag_full_s > POS_MAX) begin
            mag_s = POS_MAX;
        end else begin
            mag_s = mag_full_s;
        end
        idx_s      = 4'(mag_s >> FW);
        frac_s     = FW'(mag_s);
        knee_lo_s  = knee({1'b0, idx_s});
        knee_hi_s  = knee({1'b0, idx_s} + 5'd1);
        interp_s   = {{FW{1'b0}}, (knee_hi_s - knee_lo_s)} * {{WIDTH{1'b0}}, frac_s};
        soft_mag_s = knee_lo_s + WIDTH'(interp_s >> FW);
        soft_s     = neg_s ? -soft_mag_s : soft_mag_s;
    end

    // Mode selection between the shaping curves.
    always_comb begin
        y = x;
        case (mode)
            BYPASS: y = x;
            HARD: begin
                if (x > threshold) begin
                    y = threshold;
                end else if (x < lo_hard_s) begin
                    y = lo_hard_s;
                end else begin
                    y = x;
                end
            end
            SOFT: y = soft_s;
            ASYM: begin
                if (x > threshold) begin
                    y = threshold;
                end else if (x < lo_asym_s) begin
                    y = lo_asym_s;
                end else begin
                    y = x;
                end
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/multimode_distortion.sv
// Three-stage distortion pipeline (gain -> shape -> dry/wet mix) behind a
// valid/ready handshake. Each sample carries the configuration that was in
// the shadow registers when it was accepted, so reconfiguration lands
// exactly on a sample boundary.
module multimode_distortion
    import dist_pkg::*;
#(
    parameter int WIDTH     = DIST_WIDTH,
    parameter int GAIN_W    = DIST_GAIN_W,
    parameter int GAIN_FRAC = DIST_GAIN_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sample,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_mode,
    input  logic [GAIN_W-1:0] cfg_gain,
    input  logic [WIDTH-1:0]  cfg_threshold,
    input  logic [7:0]        cfg_mix
);

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam int MW = WIDTH + 10;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    dist_cfg_t               shadow_d, shadow_q;
    logic                    v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic signed [WIDTH-1:0] g1_d, g1_q, dry1_d, dry1_q;
    dist_mode_e              mode1_d, mode1_q;
    logic signed [WIDTH-1:0] thr1_d, thr1_q;
    logic [7:0]              mix1_d, mix1_q, mix2_d, mix2_q;
    logic signed [WIDTH-1:0] wet2_d, wet2_q, dry2_d, dry2_q;
    logic [WIDTH-1:0]        out3_d, out3_q;

    logic                    adv_s, accept_s;
    logic [WIDTH-1:0]        thr_clean_s;
    logic signed [PW-1:0]    gain_a_s, gain_b_s, prod_s, shift_s;
    logic signed [WIDTH-1:0] gained_s, shaped_s;
    logic [8:0]              mix_m_s, mix_dm_s;
    logic signed [MW-1:0]    wet_x_s, dry_x_s, mix_sum_s;
    logic [WIDTH-1:0]        mixed_s;

    assign adv_s     = !v3_q || out_ready;
    assign in_ready  = adv_s && !rst;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = v3_q;
    assign out_sample = out3_q;

    dist_shaper #(.WIDTH(WIDTH)) u_shaper (
        .mode      (mode1_q),
        .threshold (thr1_q),
        .x         (g1_q),
        .y         (shaped_s)
    );

    // S1 arithmetic: full-width signed x unsigned gain product, Q-format
    // shift back to sample scale, then saturation to the sample range.
    always_comb begin
        gain_a_s = {{(PW-WIDTH){in_sample[WIDTH-1]}}, in_sample};
        gain_b_s = {{(PW-GAIN_W){1'b0}}, shadow_q.gain};
        prod_s   = gain_a_s * gain_b_s;
        shift_s  = prod_s >>> GAIN_FRAC;
        if (shift_s > SAT_MAX) begin
            gained_s = WIDTH'(SAT_MAX);
        end else if (shift_s < SAT_MIN) begin
            gained_s = WIDTH'(SAT_MIN);
        end else begin
            gained_s = WIDTH'(shift_s);
        end
    end

    // S3 arithmetic: weighted dry/wet blend; the weights sum to 256 so the
    // result always fits back into the sample width.
    always_comb begin
        if (mix2_q == 8'hFF) begin
            mix_m_s = MIX_FULL;
        end else begin
            mix_m_s = {1'b0, mix2_q};
        end
        mix_dm_s  = MIX_FULL - mix_m_s;
        wet_x_s   = {{10{wet2_q[WIDTH-1]}}, wet2_q};
        dry_x_s   = {{10{dry2_q[WIDTH-1]}}, dry2_q};
        mix_sum_s = wet_x_s * $signed({{(MW-9){1'b0}}, mix_m_s})
                  + dry_x_s * $signed({{(MW-9){1'b0}}, mix_dm_s});
        mixed_s   = WIDTH'(mix_sum_s >>> 8);
    end

    // Negative clip levels make no sense; pin them to zero on load.
    always_comb begin
        if (cfg_threshold[WIDTH-1]) begin
            thr_clean_s = {WIDTH{1'b0}};
        end else begin
            thr_clean_s = cfg_threshold;
        end
    end

    // Next-state for shadow config and all three stages; everything freezes
    // together when the output is stalled.
    always_comb begin
        if (cfg_valid) begin
            shadow_d.mode      = dist_mode_e'(cfg_mode);
            shadow_d.gain      = cfg_gain;
            shadow_d.threshold = thr_clean_s;
            shadow_d.mix       = cfg_mix;
        end else begin
            shadow_d = shadow_q;
        end

        v1_d = v1_q;  g1_d = g1_q;  dry1_d = dry1_q;
        mode1_d = mode1_q;  thr1_d = thr1_q;  mix1_d = mix1_q;
        v2_d = v2_q;  wet2_d = wet2_q;  dry2_d = dry2_q;  mix2_d = mix2_q;
        v3_d = v3_q;  out3_d = out3_q;

        if (adv_s) begin
            v1_d = accept_s;
            if (accept_s) begin
                g1_d    = gained_s;
                dry1_d  = in_sample;
                mode1_d = shadow_q.mode;
                thr1_d  = shadow_q.threshold;
                mix1_d  = shadow_q.mix;
            end else begin
                g1_d = g1_q;
            end

            v2_d = v1_q;
            if (v1_q) begin
                wet2_d = shaped_s;
                dry2_d = dry1_q;
                mix2_d = mix1_q;
            end else begin
                wet2_d = wet2_q;
            end

            v3_d = v2_q;
            if (v2_q) begin
                out3_d = mixed_s;
            end else begin
                out3_d = out3_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // State registers with synchronous reset; reset discards in-flight samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= CFG_RESET;
            v1_q     <= 1'b0;
            g1_q     <= {WIDTH{1'b0}};
            dry1_q   <= {WIDTH{1'b0}};
            mode1_q  <= BYPASS;
            thr1_q   <= {WIDTH{1'b0}};
            mix1_q   <= 8'd0;
            v2_q     <= 1'b0;
            wet2_q   <= {WIDTH{1'b0}};
            dry2_q   <= {WIDTH{1'b0}};
            mix2_q   <= 8'd0;
            v3_q     <= 1'b0;
            out3_q   <= {WIDTH{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            v1_q     <= v1_d;
            g1_q     <= g1_d;
            dry1_q   <= dry1_d;
            mode1_q  <= mode1_d;
            thr1_q   <= thr1_d;
            mix1_q   <= mix1_d;
            v2_q     <= v2_d;
            wet2_q   <= wet2_d;
            dry2_q   <= dry2_d;
            mix2_q   <= mix2_d;
            v3_q     <= v3_d;
            out3_q   <= out3_d;
        end
    end

endmodule

// File: tb/tb_multimode_distortion.sv
// Directed bench for multimode_distortion. A sample-level model predicts
// each output from the configuration seen at acceptance; a negedge monitor
// compares every output transfer, latency, stall stability and reset.
module tb_multimode_distortion;

    localparam int NONE = 999999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sample;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_gain = 8'd0;
    logic [15:0] cfg_threshold = 16'd0;
    logic [7:0]  cfg_mix = 8'd0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int exp_q[$];
    int acc_q[$];
    int lit_q[$];
    int sh_mode = 0, sh_gain = 16, sh_thr = 32767, sh_mix = 255;
    bit lat_chk = 1'b1, post_rst = 1'b0, stall_prev = 1'b0;
    int held = 0;
    int e_v, a_v, l_v, thr_v;

    multimode_distortion dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_gain(cfg_gain),
        .cfg_threshold(cfg_threshold), .cfg_mix(cfg_mix)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Soft curve y = a*(2-a) in full-scale units, sampled every 1/16.
    function automatic int knee(input int k);
        int v;
        v = 128 * k * (32 - k);
        return (v > 32767) ? 32767 : v;
    endfunction

    function automatic int model(input int s, input int mode, input int gain,
                                 input int thr, input int mix);
        int g, w, a, k, f, y, m;
        g = (s * gain) >>> 4;
        if (g > 32767)  g = 32767;
        if (g < -32768) g = -32768;
        case (mode)
            0: w = g;
            1: w = (g > thr) ? thr : ((g < -thr) ? -thr : g);
            2: begin
                a = (g < 0) ? -g : g;
                if (a > 32767) a = 32767;
                k = a / 2048;
                f = a % 2048;
                y = knee(k) + ((knee(k + 1) - knee(k)) * f) / 2048;
                w = (g < 0) ? -y : y;
            end
            default: w = (g > thr) ? thr : ((g < -(thr >>> 1)) ? -(thr >>> 1) : g);
        endcase
        m = (mix == 255) ? 256 : mix;
        return (w * m + s * (256 - m)) >>> 8;
    endfunction

    // Monitor: mid-cycle view of the handshake, scoreboard against the model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            sh_mode = 0; sh_gain = 16; sh_thr = 32767; sh_mix = 255;
            post_rst = 1'b1;
            stall_prev = 1'b0;
        end else begin
            if (post_rst) begin
                chk("reset_out_valid", int'(out_valid), 0);
                chk("reset_out_sample", int'($signed(out_sample)), 0);
                post_rst = 1'b0;
            end
            if (stall_prev) begin
                chk("stall_valid_held", int'(out_valid), 1);
                chk("stall_sample_held", int'($signed(out_sample)), held);
            end
            if (out_valid && out_ready) begin
                chk("output_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e_v = exp_q.pop_front();
                    a_v = acc_q.pop_front();
                    chk("out_sample", int'($signed(out_sample)), e_v);
                    if (lat_chk) chk("latency", cyc - a_v, 3);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = int'($signed(out_sample));
            if (in_valid && in_ready) begin
                e_v = model(int'($signed(in_sample)), sh_mode, sh_gain, sh_thr, sh_mix);
                exp_q.push_back(e_v);
                acc_q.push_back(cyc);
                if (lit_q.size() > 0) begin
                    l_v = lit_q.pop_front();
                    if (l_v != NONE) chk("model_pin", e_v, l_v);
                end
            end
            if (cfg_valid) begin
                thr_v   = int'($signed(cfg_threshold));
                sh_mode = int'(cfg_mode);
                sh_gain = int'(cfg_gain);
                sh_thr  = (thr_v < 0) ? 0 : thr_v;
                sh_mix  = int'(cfg_mix);
            end
        end
    end

    task automatic set_cfg(input int mode, input int gain, input int thr, input int mix);
        cfg_valid = 1'b1;
        cfg_mode = 2'(mode); cfg_gain = 8'(gain);
        cfg_threshold = 16'(thr); cfg_mix = 8'(mix);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send(input int s, input int lit);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_sample = 16'(s);
        lit_q.push_back(lit);
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        chk("send_accepted", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Unity bypass and full-scale negative.
        set_cfg(0, 16, 32767, 255);
        send(1000, 1000);   drain();
        send(-32768, -32768); drain();

        // Gain saturation.
        set_cfg(0, 255, 32767, 255);
        send(10000, 32767); send(-10000, -32768); drain();

        // Hard clip, including a negative threshold forced to zero.
        set_cfg(1, 16, 8000, 255);
        send(-12000, -8000); send(5000, 5000); send(8000, 8000); drain();
        set_cfg(1, 16, -5, 255);
        send(300, 0); drain();

        // Asymmetric clip.
        set_cfg(3, 16, 8001, 255);
        send(9000, 8001); send(-9000, -4000); drain();

        // Dry/wet mix.
        set_cfg(1, 16, 4000, 128);
        send(8000, 6000); drain();
        set_cfg(1, 16, 4000, 0);
        send(8000, 8000); drain();

        // Soft curve: breakpoints, interpolation and odd symmetry.
        set_cfg(2, 16, 32767, 255);
        send(2048, 3968); send(-2048, -3968); send(0, 0); send(3072, 5824); drain();

        // Ramp with a 5-cycle output stall in the middle.
        set_cfg(1, 32, 6000, 200);
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(-4500 + 1000 * i, NONE);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Config strobe in the same cycle as sample 2's acceptance.
        set_cfg(0, 16, 32767, 255);
        for (int i = 0; i < 5; i++) begin
            cfg_valid = (i == 2);
            cfg_mode = 2'd1; cfg_gain = 8'd16; cfg_threshold = 16'd100; cfg_mix = 8'd255;
            case (i)
                0: send(200, 200);
                1: send(300, 300);
                2: send(400, 400);
                3: send(500, 100);
                default: send(600, 100);
            endcase
        end
        cfg_valid = 1'b0;
        drain();

        // Reset with samples in flight; nothing stale may emerge afterwards.
        send(11, 11); send(22, 22); send(33, 33); send(44, 44);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        send(777, 777);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multimode_distortion.md
# multimode_distortion

Pipelined, parametrised distortion stage for the guitar effects chain. It applies a saturating pre-gain, then one of four waveshaping modes, then a dry/wet mix. A valid/ready stream handshake carries samples in and out. Configuration is captured with every sample, so a parameter change takes effect exactly on a sample boundary and never glitches a sample already in flight. It sits between the input conditioning block and the downstream effects in the per-channel audio path.

## Interface
- WIDTH, 16, sample width (signed two's complement).
- GAIN_W, 8, pre-gain width (unsigned Q4.4 when 8).
- GAIN_FRAC, 4, fractional bits of the gain.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_sample  in  WIDTH  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_sample  out  WIDTH  signed processed sample.
- cfg_valid  in  1  single-cycle strobe; load cfg_* into the shadow registers.
- cfg_mode  in  2  0 bypass, 1 hard clip, 2 soft clip, 3 asymmetric clip.
- cfg_gain  in  GAIN_W  unsigned pre-gain.
- cfg_threshold  in  WIDTH  clip level T. Treated as signed; a negative value is forced to 0.
- cfg_mix  in  8  wet amount. 0 means fully dry; 255 maps to 256, fully wet.

## Operation
**Pipeline handshake**
- The pipeline has 3 stages, S1 to S3. Each stage holds a valid bit, its data, and the config snapshot that travels with the sample.
- Advance signal: adv = !out_valid || out_ready.
- in_ready = adv && !rst.
- A sample is accepted when in_valid && in_ready.

**Configuration**
- cfg_valid updates the shadow registers in the same cycle. It is always accepted; there is no ready signal.
- A sample captures the shadow config at the moment it is accepted.
- If cfg_valid and acceptance happen in the same cycle, that sample uses the OLD config.

**S1 (gain)**
- p = in_sample * gain, computed at full width (WIDTH+GAIN_W+1 bits).
- p is arithmetic-shifted right by GAIN_FRAC.
- The result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- The raw in_sample is carried forward as the dry value.

**S2 (shape)**
- Mode 0: wet = gained sample.
- Mode 1: clamp to [-T, +T].
- Mode 2: wet = LUT(gained sample), the odd-symmetric soft curve.
- Mode 3: clamp to [-(T>>>1), +T]. This is asymmetric, producing even harmonics.

**S3 (mix)**
- out = (wet*m + dry*(256-m)) >>> 8, where m = (mix==255) ? 256 : mix.
- The sum is computed at WIDTH+10 bits; no saturation is needed.

**Reset**
- All valid bits clear and out_sample = 0.
- Shadow config resets to: mode 0, gain 1.0 (1 << GAIN_FRAC), T = 2^(WIDTH-1)-1, mix 255.
- Reset mid-stream drops every in-flight sample with no output.

## Timing
- Latency is 3 cycles from acceptance to out_valid when there is no backpressure.
- Throughput is 1 sample per cycle.
- When out_ready=0 with out_valid=1:
  - The whole pipeline freezes.
  - in_ready = 0.
  - out_sample and out_valid stay stable.
- Bubbles (in_valid=0) propagate as invalid stages. They do not cause stalls.
- Samples are never dropped, duplicated, or reordered.
- cfg_valid has no effect on samples already accepted.

## Structure
- Package dist_pkg holds:
  - the dist_mode_e enum (BYPASS, HARD, SOFT, ASYM);
  - the dist_cfg_t struct (mode, gain, threshold, mix);
  - the reset defaults;
  - the MIX_FULL constant (256).
- Sub-module dist_shaper holds the combinational S2 logic: mode mux, clamps, and soft-clip LUT. It is registered by the parent.
- The parent holds the stage registers, the handshake, the shadow config, gain, and mix.

## Test plan
- Unity bypass: mode 0, gain 0x10, mix 255; input 1000 → 1000 exactly 3 cycles later. Then input -32768 → -32768.
- Gain saturation: gain 0xFF; input 10000 → 32767; input -10000 → -32768.
- Hard clip: T = 8000; inputs -12000, 5000, 8000 → -8000, 5000, 8000. With T = -5: input 300 → 0.
- Asymmetric clip: T = 8001; input 9000 → 8001; input -9000 → -4000.
- Mix: mode 1, T = 4000, mix 128, gain 1.0; input 8000 → 6000. With mix 0: input 8000 → 8000.
- Backpressure and config timing:
  - Stream 10 ramp samples while holding out_ready low for 5 cycles mid-stream. Outputs stay ordered and complete, and out_sample holds stable while stalled.
  - Assert cfg_valid (mode 1, T = 100) in the same cycle sample k is accepted. Sample k is processed with the old config; k+1 and later are clipped.
  - Assert rst mid-stream. out_valid = 0 on the next cycle and no stale output appears afterwards.
